// File: rtl/tmds_pkg.sv
// Shared definitions for TMDS channel-0 word alignment: control tokens, FSM state
// encoding and the number of word-boundary offsets.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_0 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_1 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_2 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_3 = 10'h2AB;

    localparam int WORD_OFFSETS = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == CTRL_TOKEN_0) || (w == CTRL_TOKEN_1) ||
               (w == CTRL_TOKEN_2) || (w == CTRL_TOKEN_3);
    endfunction

endpackage

// File: rtl/tmds_window_counter.sv
// Counts valid words and control tokens over a WINDOW-word window; flags the
// closing word combinationally so the FSM acts on it at the same edge.
module tmds_window_counter
    import tmds_pkg::*;
#(
    parameter int WINDOW   = 1024,
    parameter int MIN_CTRL = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       word_valid,
    input  logic [9:0] word,
    output logic       window_done,
    output logic       window_good
);

    localparam int WW = $clog2(WINDOW);
    localparam int TW = $clog2(MIN_CTRL + 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WINDOW - 1);
    localparam logic [TW-1:0] TOK_SAT   = TW'(MIN_CTRL);
    localparam logic [TW-1:0] TOK_NEAR  = TW'(MIN_CTRL - 1);

    logic [WW-1:0] word_cnt;
    logic [TW-1:0] tok_cnt;
    logic          hit;

    assign hit         = word_valid && is_ctrl_token(word);
    assign window_done = word_valid && !clear && (word_cnt == WORD_LAST);
    // The closing word itself may be the token that makes the window good.
    assign window_good = window_done && ((tok_cnt == TOK_SAT) || (hit && tok_cnt == TOK_NEAR));

    always_ff @(posedge clk) begin
        if (reset || clear || window_done) begin
            word_cnt <= '0;
            tok_cnt  <= '0;
        end else if (word_valid) begin
            word_cnt <= word_cnt + 1'b1;
            if (hit && tok_cnt != TOK_SAT)
                tok_cnt <= tok_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tmds_align_ctrl.sv
// Channel-0 word-boundary alignment FSM driving the deserializer bitslip.
// Define TMDS_ALIGN_DELAY_SCAN_EN to step pll_delay on every slip_count wrap.
module tmds_align_ctrl
    import tmds_pkg::*;
#(
    parameter int WINDOW       = 1024,
    parameter int MIN_CTRL     = 8,
    parameter int LOCK_WINDOWS = 4,
    parameter int LOSS_WINDOWS = 2,
    parameter int SETTLE       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hdmi_locked,
    input  logic       word_valid,
    input  logic [9:0] word,
    output logic       bitslip,
    output logic [3:0] pll_delay,
    output logic [3:0] slip_count,
    output logic       aligned,
    output logic [2:0] state_dbg
);

    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int BW = $clog2(LOSS_WINDOWS + 1);
    localparam int SW = $clog2(SETTLE + 1);

    align_state_t  state;
    logic [GW-1:0] good_run;
    logic [BW-1:0] bad_run;
    logic [SW-1:0] settle_cnt;
    logic          win_clear, window_done, window_good;
    logic          do_slip, slip_wrap;

    // Words only count while hunting or locked; everything else keeps the window empty.
    assign win_clear = !hdmi_locked || (state != ST_SEARCH && state != ST_LOCKED);

    tmds_window_counter #(
        .WINDOW   (WINDOW),
        .MIN_CTRL (MIN_CTRL)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .clear       (win_clear),
        .word_valid  (word_valid),
        .word        (word),
        .window_done (window_done),
        .window_good (window_good)
    );

    assign do_slip = window_done && !window_good &&
                     ((state == ST_SEARCH) ||
                      (state == ST_LOCKED && bad_run == BW'(LOSS_WINDOWS - 1)));
    assign slip_wrap = (slip_count == 4'(WORD_OFFSETS - 1));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            good_run   <= '0;
            bad_run    <= '0;
            settle_cnt <= '0;
        end else if (!hdmi_locked) begin
            state      <= ST_IDLE;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            good_run   <= '0;
            bad_run    <= '0;
            settle_cnt <= '0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state      <= ST_SEARCH;
                    good_run   <= '0;
                    bad_run    <= '0;
                    settle_cnt <= '0;
                end
                ST_SEARCH: begin
                    if (do_slip) begin
                        state    <= ST_SLIP;
                        bitslip  <= 1'b1;
                        good_run <= '0;
                        bad_run  <= '0;
                    end else if (window_done) begin
                        if (good_run == GW'(LOCK_WINDOWS - 1)) begin
                            state    <= ST_LOCKED;
                            aligned  <= 1'b1;
                            good_run <= '0;
                            bad_run  <= '0;
                        end else begin
                            good_run <= good_run + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE - 1))
                        state <= ST_SEARCH;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                ST_LOCKED: begin
                    if (do_slip) begin
                        state    <= ST_SLIP;
                        bitslip  <= 1'b1;
                        aligned  <= 1'b0;
                        good_run <= '0;
                        bad_run  <= '0;
                    end else if (window_done) begin
                        bad_run <= window_good ? '0 : bad_run + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Offset advances on SLIP entry so slip_count changes together with bitslip.
    always_ff @(posedge clk) begin
        if (reset)
            slip_count <= '0;
        else if (do_slip)
            slip_count <= slip_wrap ? 4'd0 : slip_count + 4'd1;
    end

`ifdef TMDS_ALIGN_DELAY_SCAN_EN
    logic [3:0] pll_q;

    always_ff @(posedge clk) begin
        if (reset)
            pll_q <= '0;
        else if (do_slip && slip_wrap)
            pll_q <= pll_q + 4'd1;
    end

    assign pll_delay = pll_q;
`else
    assign pll_delay = 4'd0;
`endif

endmodule
